// File: rtl/l2cache_flex_if.sv
//------------------------------------------------------------------------------
// l2cache_flex_if
// Request/response bundle between the requester, the cache slice and DRAM.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface l2cache_flex_if #(
  parameter int ADDR_BITS  = 32,
  parameter int LINE_BYTES = 32
) ();
  logic [ADDR_BITS-1:0]      ufp_addr;
  logic                      ufp_read;
  logic                      ufp_write;
  logic [LINE_BYTES-1:0]     ufp_wmask;
  logic [LINE_BYTES*8-1:0]   ufp_wdata;
  logic [LINE_BYTES*8-1:0]   ufp_rdata;
  logic                      ufp_resp;
  logic                      flush_req;
  logic                      flush_done;
  logic                      busy;
  logic [ADDR_BITS-1:0]      dfp_addr;
  logic                      dfp_read;
  logic                      dfp_write;
  logic [LINE_BYTES*8-1:0]   dfp_wdata;
  logic [LINE_BYTES*8-1:0]   dfp_rdata;
  logic                      dfp_resp;

  // cache side
  modport slave (
    input  ufp_addr, ufp_read, ufp_write, ufp_wmask, ufp_wdata, flush_req,
           dfp_rdata, dfp_resp,
    output ufp_rdata, ufp_resp, flush_done, busy, dfp_addr, dfp_read,
           dfp_write, dfp_wdata
  );

  // requester and memory side
  modport master (
    output ufp_addr, ufp_read, ufp_write, ufp_wmask, ufp_wdata, flush_req,
           dfp_rdata, dfp_resp,
    input  ufp_rdata, ufp_resp, flush_done, busy, dfp_addr, dfp_read,
           dfp_write, dfp_wdata
  );
endinterface

`default_nettype wire

// File: rtl/l2cache_flex.sv
//------------------------------------------------------------------------------
// l2cache_flex
// Write-back, write-allocate set-associative cache slice with tree-PLRU and flush.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module l2cache_flex #(
  parameter int WAYS       = 4,
  parameter int SETS       = 16,
  parameter int LINE_BYTES = 32,
  parameter int ADDR_BITS  = 32
) (
  input  logic          clk,
  input  logic          rst,
  l2cache_flex_if.slave bus
);
  localparam int c_line_bits = LINE_BYTES * 8;
  localparam int c_off_bits  = $clog2(LINE_BYTES);
  localparam int c_idx_bits  = $clog2(SETS);
  localparam int c_way_bits  = $clog2(WAYS);
  localparam int c_tag_bits  = ADDR_BITS - c_off_bits - c_idx_bits;
  localparam int c_ptr_bits  = c_idx_bits + c_way_bits;

  localparam logic [2:0] c_idle       = 3'd0;
  localparam logic [2:0] c_compare    = 3'd1;
  localparam logic [2:0] c_writeback  = 3'd2;
  localparam logic [2:0] c_allocate   = 3'd3;
  localparam logic [2:0] c_flush_scan = 3'd4;
  localparam logic [2:0] c_flush_wb   = 3'd5;
  localparam logic [2:0] c_flush_done = 3'd6;

  logic [2:0]                      r_state;
  logic [ADDR_BITS-c_off_bits-1:0] r_line;
  logic                            r_write;
  logic [LINE_BYTES-1:0]           r_wmask;
  logic [c_line_bits-1:0]          r_wdata;
  logic [c_way_bits-1:0]           r_victim;
  logic [c_ptr_bits-1:0]           r_fptr;

  logic                            r_valid [SETS][WAYS];
  logic                            r_dirty [SETS][WAYS];
  logic [c_tag_bits-1:0]           r_tag   [SETS][WAYS];
  logic [c_line_bits-1:0]          r_data  [SETS][WAYS];
  logic [WAYS-2:0]                 r_plru  [SETS];

  logic [c_idx_bits-1:0] w_idx;
  logic [c_tag_bits-1:0] w_tag;
  logic [WAYS-1:0]       w_hit_vec;
  logic [WAYS-1:0]       w_inv_vec;
  logic                  w_hit;
  logic [c_way_bits-1:0] w_hit_way;
  logic [c_way_bits-1:0] w_inv_way;
  logic [c_way_bits-1:0] w_plru_way;
  logic [c_way_bits-1:0] w_victim;
  logic [WAYS-2:0]       w_plru_upd;
  int                    w_node;
  int                    w_unode;
  logic [c_idx_bits-1:0] w_fset;
  logic [c_way_bits-1:0] w_fway;
  logic                  w_flast;

  assign w_idx   = r_line[c_idx_bits-1:0];
  assign w_tag   = r_line[c_idx_bits +: c_tag_bits];
  assign w_fset  = r_fptr[c_way_bits +: c_idx_bits];
  assign w_fway  = r_fptr[c_way_bits-1:0];
  assign w_flast = &r_fptr;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    assign w_hit_vec[g] = r_valid[w_idx][g] && (r_tag[w_idx][g] == w_tag);
    assign w_inv_vec[g] = !r_valid[w_idx][g];
  end

  always_comb begin
    w_hit     = |w_hit_vec;
    w_hit_way = '0;
    w_inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_hit_vec[w]) w_hit_way = c_way_bits'(w);
      if (w_inv_vec[w]) w_inv_way = c_way_bits'(w);
    end
  end

  // Heap-ordered tree: node n has children 2n/2n+1, bit n-1 set means "go right".
  always_comb begin
    w_node = 1;
    for (int l = 0; l < c_way_bits; l++)
      w_node = 2 * w_node + (r_plru[w_idx][w_node-1] ? 1 : 0);
    w_plru_way = c_way_bits'(w_node - WAYS);
  end

  always_comb begin
    w_plru_upd = r_plru[w_idx];
    w_unode    = int'(w_hit_way) + WAYS;
    for (int l = 0; l < c_way_bits; l++) begin
      w_plru_upd[(w_unode >> 1) - 1] = ~w_unode[0];
      w_unode = w_unode >> 1;
    end
  end

  assign w_victim = (|w_inv_vec) ? w_inv_way : w_plru_way;

  always_comb begin
    bus.ufp_resp   = 1'b0;
    bus.ufp_rdata  = '0;
    bus.flush_done = 1'b0;
    bus.busy       = (r_state != c_idle);
    bus.dfp_read   = 1'b0;
    bus.dfp_write  = 1'b0;
    bus.dfp_addr   = '0;
    bus.dfp_wdata  = '0;
    case (r_state)
      c_compare: begin
        if (w_hit) begin
          bus.ufp_resp  = 1'b1;
          bus.ufp_rdata = r_data[w_idx][w_hit_way];
        end
      end
      c_writeback: begin
        bus.dfp_write = 1'b1;
        bus.dfp_addr  = {r_tag[w_idx][r_victim], w_idx, {c_off_bits{1'b0}}};
        bus.dfp_wdata = r_data[w_idx][r_victim];
      end
      c_allocate: begin
        bus.dfp_read = 1'b1;
        bus.dfp_addr = {w_tag, w_idx, {c_off_bits{1'b0}}};
      end
      c_flush_wb: begin
        bus.dfp_write = 1'b1;
        bus.dfp_addr  = {r_tag[w_fset][w_fway], w_fset, {c_off_bits{1'b0}}};
        bus.dfp_wdata = r_data[w_fset][w_fway];
      end
      c_flush_done: bus.flush_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= c_idle;
      r_fptr   <= '0;
      r_victim <= '0;
      r_write  <= 1'b0;
      for (int s = 0; s < SETS; s++) begin
        r_plru[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_dirty[s][w] <= 1'b0;
        end
      end
    end else begin
      case (r_state)
        c_idle: begin
          if (bus.flush_req) begin
            r_fptr  <= '0;
            r_state <= c_flush_scan;
          end else if (bus.ufp_read || bus.ufp_write) begin
            r_line  <= bus.ufp_addr[ADDR_BITS-1:c_off_bits];
            r_write <= bus.ufp_write;
            r_wmask <= bus.ufp_wmask;
            r_wdata <= bus.ufp_wdata;
            r_state <= c_compare;
          end
        end
        c_compare: begin
          if (w_hit) begin
            r_plru[w_idx] <= w_plru_upd;
            if (r_write) begin
              for (int b = 0; b < LINE_BYTES; b++)
                if (r_wmask[b]) r_data[w_idx][w_hit_way][b*8 +: 8] <= r_wdata[b*8 +: 8];
              r_dirty[w_idx][w_hit_way] <= 1'b1;
            end
            r_state <= c_idle;
          end else begin
            r_victim <= w_victim;
            r_state  <= (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim])
                        ? c_writeback : c_allocate;
          end
        end
        c_writeback: begin
          if (bus.dfp_resp) begin
            r_dirty[w_idx][r_victim] <= 1'b0;
            r_state <= c_allocate;
          end
        end
        c_allocate: begin
          if (bus.dfp_resp) begin
            r_tag[w_idx][r_victim]   <= w_tag;
            r_data[w_idx][r_victim]  <= bus.dfp_rdata;
            r_valid[w_idx][r_victim] <= 1'b1;
            r_dirty[w_idx][r_victim] <= 1'b0;
            r_state <= c_compare;
          end
        end
        c_flush_scan: begin
          if (r_valid[w_fset][w_fway] && r_dirty[w_fset][w_fway]) r_state <= c_flush_wb;
          else if (w_flast)                                      r_state <= c_flush_done;
          else                                                   r_fptr  <= r_fptr + 1'b1;
        end
        c_flush_wb: begin
          if (bus.dfp_resp) begin
            r_dirty[w_fset][w_fway] <= 1'b0;
            if (w_flast) begin
              r_state <= c_flush_done;
            end else begin
              r_fptr  <= r_fptr + 1'b1;
              r_state <= c_flush_scan;
            end
          end
        end
        c_flush_done: r_state <= c_idle;
        default:      r_state <= c_idle;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: doc/l2cache_flex.md
# l2cache_flex

Parametrised, non-coherent, write-back, write-allocate set-associative cache slice. Line width, way count, set count and address width are all configurable. Supports byte-masked line writes, a first-invalid-then-tree-PLRU replacement policy and a full-cache flush command. It sits between an upstream line-granular requester (L1 or bus adapter) and DRAM, and is the stand-alone building block for future L2/LLC banks.

## Interface
- WAYS, 4, associativity; power of two, ≥2
- SETS, 16, sets; power of two, ≥2
- LINE_BYTES, 32, bytes per line; power of two, ≥4
- ADDR_BITS, 32, byte-address width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ufp_addr  in  ADDR_BITS  request byte address; offset bits ignored
- ufp_read  in  1  line read request
- ufp_write  in  1  line write request
- ufp_wmask  in  LINE_BYTES  byte enables for writes
- ufp_wdata  in  LINE_BYTES*8  write data
- ufp_rdata  out  LINE_BYTES*8  read data; valid only while ufp_resp=1
- ufp_resp  out  1  one-cycle completion pulse
- flush_req  in  1  request to write back all dirty lines
- flush_done  out  1  one-cycle pulse when the flush completes
- busy  out  1  high in every state except IDLE
- dfp_addr  out  ADDR_BITS  line-aligned memory address
- dfp_read  out  1  memory line read
- dfp_write  out  1  memory line write
- dfp_wdata  out  LINE_BYTES*8  writeback data
- dfp_rdata  in  LINE_BYTES*8  fill data; valid when dfp_resp=1
- dfp_resp  in  1  memory completion pulse

## Operation
- Address split: offset = log2(LINE_BYTES) bits, index = log2(SETS) bits, tag = the remaining bits.
- Storage uses flip-flop arrays per way: valid, dirty, tag, data. Each set also holds WAYS-1 tree-PLRU bits.
- FSM states: IDLE, COMPARE, WRITEBACK, ALLOCATE, FLUSH_SCAN, FLUSH_WB, FLUSH_DONE.
- IDLE
  - If flush_req=1, go to FLUSH_SCAN. Flush has priority over ufp_read/ufp_write.
  - Otherwise, if ufp_read or ufp_write is high, latch addr/wmask/wdata/op and go to COMPARE.
  - If both ufp_read and ufp_write are high, the request is treated as a write.
- COMPARE
  - Hit (valid and tag match), read: ufp_rdata = line, ufp_resp=1, go to IDLE.
  - Hit, write: merge bytes where wmask=1, set dirty, ufp_resp=1, go to IDLE.
  - Miss: select a victim. The victim is the lowest-index invalid way; if all ways are valid, it is the PLRU way.
  - Miss with victim valid and dirty: go to WRITEBACK. Otherwise go to ALLOCATE.
- WRITEBACK
  - dfp_write=1, dfp_addr={victim tag, index, 0}, dfp_wdata=victim line.
  - On dfp_resp, clear the victim's dirty bit and go to ALLOCATE.
- ALLOCATE
  - dfp_read=1, dfp_addr={req tag, index, 0}.
  - On dfp_resp, write the victim way: tag=req tag, data=dfp_rdata, valid=1, dirty=0. Go to COMPARE, which now hits.
- PLRU
  - Updated only in the cycle ufp_resp=1.
  - Tree bits on the path to the accessed way are set to point away from it.
- FLUSH_SCAN
  - A pointer (set, way) starts at (0,0) and advances way-major within a set, then to the next set.
  - Valid+dirty entry: go to FLUSH_WB. Otherwise advance one entry per cycle.
  - After entry (SETS-1, WAYS-1), go to FLUSH_DONE.
- FLUSH_WB
  - Writes back the entry as in WRITEBACK. On dfp_resp, clear dirty, advance the pointer, return to FLUSH_SCAN.
  - Valid bits, tags and PLRU state are unchanged by a flush.
- FLUSH_DONE: flush_done=1 for one cycle, then go to IDLE.
- Reset: all valid, dirty and PLRU bits cleared. FSM goes to IDLE. All outputs are 0: ufp_resp, flush_done, busy, dfp_read, dfp_write, dfp_addr, dfp_wdata, ufp_rdata.
- Reset mid-transaction aborts the transaction immediately, with no writeback. A dfp_resp arriving after reset is ignored.

## Timing
- Hit latency: request seen in IDLE at cycle N; ufp_resp at N+1.
- Clean miss latency: ufp_resp comes 1 cycle after the fill's dfp_resp (the ALLOCATE→COMPARE transition).
- Dirty miss latency: writeback and fill are serialised; there is one outstanding DFP operation at most.
- Requester handshake:
  - The requester holds ufp_read/ufp_write and its operands stable until ufp_resp.
  - Inputs are latched only in IDLE.
  - A new request may be presented in the cycle after ufp_resp.
- DFP handshake:
  - dfp_read/dfp_write and dfp_addr/dfp_wdata stay constant until the cycle dfp_resp=1, and deassert the next cycle.
  - dfp_read and dfp_write are never high together.
- A flush of a fully clean cache takes SETS*WAYS+2 cycles from the cycle flush_req is accepted to flush_done.
- flush_req is sampled only in IDLE. Holding it high after flush_done starts another flush.

## Test plan
- Reset, then read 0x0000_0100 with dfp_rdata=0xA5 pattern → one dfp_read at 0x100. ufp_rdata=pattern 1 cycle after dfp_resp. A repeat read hits, with ufp_resp at the next cycle and no DFP activity.
- Write 0x100, wmask=0x0000_000F, wdata low word=0xDEADBEEF, on a resident line → only bytes 0-3 change. A later read returns the merged line.
- WAYS=4, SETS=16: fill 5 lines with the same index (0x000, 0x200, 0x400, 0x600, 0x800); the first line is dirty → dfp_write at 0x000 with the dirty data, then dfp_read at 0x800. With no reaccess, the PLRU victim is way 0.
- Dirty lines at sets 0 and 15, then flush_req → exactly two dfp_writes, in order 0x000 then 0x1E0. Then flush_done; later reads of those lines still hit.
- rst asserted while dfp_write is pending in WRITEBACK → all outputs are 0 in the next cycle. A subsequent read of the same address misses.
- LINE_BYTES=64, SETS=8, WAYS=2 build: read 0x1C0 → dfp_addr=0x1C0 (64-byte aligned), with correct 512-bit rdata.
